// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin scheduler sharing one UART transmitter among N_REQ
//            requesters; latches per-frame config and times each frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [4*N_REQ-1:0] req_cfg,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         gnt_id,
  output logic               busy,
  output logic               tx_start_n,
  output logic [7:0]         tx_din,
  output logic [1:0]         tx_par,
  output logic               tx_dnum,
  output logic               tx_snum,
  output logic               bit_tick
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW:0]   c_n         = (PW+1)'(N_REQ);
  localparam logic [BW-1:0] c_baud_last = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_ptr;
  logic [BW-1:0]      r_baud;
  logic [3:0]         r_bitidx;
  logic [N_REQ-1:0]   r_gnt;
  logic [2:0]         r_gnt_id;
  logic [7:0]         r_tx_din;
  logic [1:0]         r_tx_par;
  logic               r_tx_dnum;
  logic               r_tx_snum;

  logic [2*N_REQ-1:0] w_req2;
  logic [N_REQ-1:0]   w_rot;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_win;
  logic [PW:0]        w_inc;
  logic [PW-1:0]      w_ptr_nxt;
  logic [N_REQ-1:0]   w_onehot;
  logic [7:0]         w_sel_data;
  logic [3:0]         w_sel_cfg;
  logic               w_any;
  logic               w_grant;
  logic               w_busy;
  logic               w_tick;
  logic [3:0]         w_last_bit;

  // Rotating the doubled request vector by ptr puts the search origin at bit 0.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_ptr +: N_REQ];
  assign w_any  = |req;

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k[PW-1:0];
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win     = (w_sum >= c_n) ? PW'(w_sum - c_n) : w_sum[PW-1:0];
  assign w_inc     = {1'b0, w_win} + (PW+1)'(1);
  assign w_ptr_nxt = (w_inc == c_n) ? '0 : w_inc[PW-1:0];
  assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

  always_comb begin
    w_sel_data = '0;
    w_sel_cfg  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == k[PW-1:0]) begin
        w_sel_data = req_data[8*k +: 8];
        w_sel_cfg  = req_cfg[4*k +: 4];
      end
    end
  end

  assign w_busy     = (r_state == S_SEND);
  assign w_grant    = (r_state == S_IDLE) && w_any;
  assign w_tick     = w_busy && (r_baud == c_baud_last);
  // Frame is start + 8 data + parity + 1 or 2 stop bits; index counts from 0.
  assign w_last_bit = r_tx_snum ? 4'd10 : 4'd11;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_SEND;
      S_SEND:  if (w_tick && (r_bitidx == w_last_bit)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_baud    <= '0;
      r_bitidx  <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_tx_din  <= '0;
      r_tx_par  <= 2'b01;
      r_tx_dnum <= 1'b0;
      r_tx_snum <= 1'b1;
    end else begin
      r_gnt <= '0;
      if (w_grant) begin
        r_gnt     <= w_onehot;
        r_gnt_id  <= 3'(w_win);
        r_tx_din  <= w_sel_data;
        r_tx_par  <= w_sel_cfg[3:2];
        r_tx_dnum <= w_sel_cfg[1];
        r_tx_snum <= w_sel_cfg[0];
        r_ptr     <= w_ptr_nxt;
        r_baud    <= '0;
        r_bitidx  <= '0;
      end else if (w_busy) begin
        r_baud <= w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) r_bitidx <= r_bitidx + 4'd1;
      end
    end
  end

  assign gnt        = r_gnt;
  assign gnt_id     = r_gnt_id;
  assign busy       = w_busy;
  assign tx_start_n = ~(w_busy && (r_bitidx == 4'd0));
  assign tx_din     = r_tx_din;
  assign tx_par     = r_tx_par;
  assign tx_dnum    = r_tx_dnum;
  assign tx_snum    = r_tx_snum;
  assign bit_tick   = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Directed self-checking bench for uart_tx_sched (N_REQ=4, CPB=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [15:0] req_cfg = '0;
  logic [3:0]  gnt;
  logic [2:0]  gnt_id;
  logic        busy;
  logic        tx_start_n;
  logic [7:0]  tx_din;
  logic [1:0]  tx_par;
  logic        tx_dnum;
  logic        tx_snum;
  logic        bit_tick;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.N_REQ(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_cfg(req_cfg),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .tx_start_n(tx_start_n),
    .tx_din(tx_din), .tx_par(tx_par), .tx_dnum(tx_dnum), .tx_snum(tx_snum),
    .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the first busy negedge; returns at the first idle negedge.
  task automatic measure(input string tag, input int exp_busy, input int exp_ticks);
    int nb, ns, nt, ng;
    nb = 0; ns = 0; nt = 0; ng = 0;
    while (busy && nb < 200) begin
      nb++;
      if (!tx_start_n) ns++;
      if (bit_tick) nt++;
      if (gnt != 4'b0) ng++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_start_low"},   ns, 4);
    chk({tag, "_ticks"},       nt, exp_ticks);
    chk({tag, "_gnt_pulses"},  ng, 1);
  endtask

  // Requests reqv from idle, expects grant to exp_id next cycle, runs the frame.
  task automatic frame(input string tag, input logic [3:0] reqv, input int exp_id,
                       input logic [3:0] req_after);
    req = reqv;
    @(negedge clk);
    chk({tag, "_gnt"},    gnt, 4'b0001 << exp_id);
    chk({tag, "_gnt_id"}, gnt_id, exp_id);
    req = req_after;
    measure(tag, 44, 11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc, lastc, t, nbad_busy, nbad_gnt, nbad_tick, nbad_start;
    int exp_ids [5];
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_n", tx_start_n, 1);
    chk("rst_din", tx_din, 0);
    chk("rst_par", tx_par, 2'b01);
    chk("rst_dnum", tx_dnum, 0);
    chk("rst_snum", tx_snum, 1);
    chk("rst_tick", bit_tick, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request, one stop bit
    req_data = 32'h0000_00A5;
    req_cfg  = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_start_n", tx_start_n, 0);
    chk("t1_din", tx_din, 8'hA5);
    chk("t1_par", tx_par, 2'b00);
    chk("t1_snum", tx_snum, 1);
    chk("t1_dnum", tx_dnum, 0);
    req = 4'b0000;
    measure("t1", 44, 11);
    chk("t1_idle_busy", busy, 0);

    // Two stop bits on channel 1; cfg/data changes mid-frame must be ignored
    req_data = 32'h0000_3C00;
    req_cfg  = {4'b0001, 4'b0001, 4'b1110, 4'b0001};
    req = 4'b0010;
    @(negedge clk);
    chk("t2_gnt", gnt, 4'b0010);
    chk("t2_din", tx_din, 8'h3C);
    chk("t2_par", tx_par, 2'b11);
    chk("t2_dnum", tx_dnum, 1);
    chk("t2_snum", tx_snum, 0);
    req = 4'b0000;
    req_cfg  = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
    req_data = 32'h0000_0000;
    measure("t2", 48, 12);
    chk("t2_hold_snum", tx_snum, 0);
    chk("t2_hold_din", tx_din, 8'h3C);
    chk("t2_hold_par", tx_par, 2'b11);

    // Contention from a freshly reset pointer
    do_reset();
    req_data = 32'h3322_1100;
    req = 4'b1111;
    cyc = 0; lastc = 0;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      do begin
        @(negedge clk);
        cyc++; t++;
      end while (gnt == 4'b0 && t < 100);
      chk("cont_id", gnt_id, exp_ids[g]);
      chk("cont_gnt", gnt, 4'b0001 << exp_ids[g]);
      chk("cont_din", tx_din, 8'h11 * exp_ids[g]);
      if (g > 0) chk("cont_period", cyc - lastc, 45);
      lastc = cyc;
    end
    req = 4'b0000;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cont_drain", busy, 0);

    // Pointer wrap: pointer is 1 here
    frame("wrap3", 4'b1000, 3, 4'b0000);
    frame("wrap0", 4'b1001, 0, 4'b1000);
    req = 4'b1000;
    @(negedge clk);
    chk("wrap3b_gnt", gnt, 4'b1000);
    req = 4'b0000;
    measure("wrap3b", 44, 11);
    frame("wrap2", 4'b0100, 2, 4'b0000);

    // Reset mid-frame at bit index 5, request held throughout
    req = 4'b0100;
    @(negedge clk);
    chk("mr_gnt", gnt, 4'b0100);
    repeat (20) @(negedge clk);
    chk("mr_pre_busy", busy, 1);
    chk("mr_pre_start_n", tx_start_n, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_start_n", tx_start_n, 1);
    chk("mr_gnt0", gnt, 0);
    chk("mr_tick", bit_tick, 0);
    @(negedge clk);
    chk("mr_hold_gnt", gnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_regnt", gnt, 4'b0100);
    chk("mr_regnt_id", gnt_id, 2);
    req = 4'b0000;
    measure("mr", 44, 11);

    // Pointer is 3 now; reset must return it to 0
    do_reset();
    frame("ptr_rst", 4'b1001, 0, 4'b0000);

    // Idle with no requests
    nbad_busy = 0; nbad_gnt = 0; nbad_tick = 0; nbad_start = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nbad_busy++;
      if (gnt != 4'b0) nbad_gnt++;
      if (bit_tick) nbad_tick++;
      if (!tx_start_n) nbad_start++;
    end
    chk("idle_busy", nbad_busy, 0);
    chk("idle_gnt", nbad_gnt, 0);
    chk("idle_tick", nbad_tick, 0);
    chk("idle_start", nbad_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
